kernel_rle_decode: RTL and testbench
====================================

# kernel_rle_decode

Streaming run-length decoder kernel: consumes the (value, count) token stream produced by the RLE encoder kernel and re-expands each run into `count` copies of `value`. It sits between two single-entry `sp_register` FIFOs in a generated FPGA device top, using the same S1 read / S2 write handshake as every other kernel, so it can be placed directly downstream of the encoder for loopback.

## Interface
Parameters:
- `WIDTH`, 16: width of data words on both streams.
- `CNT_WIDTH`, 16: width of the run-length field; must be ≤ `WIDTH`, and the count is taken from `input_S1[CNT_WIDTH-1:0]`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset). Deassertion is synchronized externally.
- `input_S1`  in  WIDTH  head word of the input FIFO, valid whenever `avail_S1`=1.
- `avail_S1`  in  1  input FIFO non-empty.
- `read_S1`  out  1  pop the input FIFO this cycle; asserted only when `avail_S1`=1.
- `output_S2`  out  WIDTH  word to push into the output FIFO.
- `write_S2`  out  1  push `output_S2` this cycle; asserted only when `afull_S2`=0.
- `afull_S2`  in  1  output FIFO cannot accept a word this cycle.
- `zero_runs`  out  16  saturating count of tokens with count = 0.
- `busy`  out  1  1 unless in `S_VAL` with no run in progress.

## Operation
- Token format: two consecutive input words, value first, then count (unsigned, 0..2^CNT_WIDTH-1). Count bits above CNT_WIDTH are ignored.
- FSM states:
  - `S_VAL`: `read_S1` = `avail_S1`. On pop, latch `input_S1` into `val_q` and go to `S_CNT`.
  - `S_CNT`: `read_S1` = `avail_S1`. On pop with count = 0: increment `zero_runs` (saturating at 0xFFFF), emit nothing, and go to `S_VAL`. On pop with count ≥ 1: load `rem_q` = count and go to `S_EMIT`.
  - `S_EMIT`: `read_S1`=0, `write_S2` = !`afull_S2`, and `output_S2` = `val_q`. Each write decrements `rem_q`. The write with `rem_q` = 1 returns the FSM to `S_VAL`.
- `read_S1` and `write_S2` are combinational from state and the FIFO flags. They are never asserted in the same cycle.
- `afull_S2`=1 in `S_EMIT` stalls with all state held. There is no timeout.
- Empty input in `S_VAL` or `S_CNT` waits indefinitely with state held.
- `output_S2` always drives `val_q`, including when `write_S2`=0.
- Reset (async, any state, including mid-run): state = `S_VAL`, `val_q`=0, `rem_q`=0, `zero_runs`=0. Resulting outputs: `read_S1`=`avail_S1`, `write_S2`=0, `output_S2`=0, `busy`=0. A partially emitted run is discarded, and a value consumed without its count is lost.

## Timing
- Pop value at cycle t, pop count at t+1 (if available). The first `write_S2` occurs at t+2, provided `afull_S2`=0.
- A run of N occupies N output cycles when unstalled. Each token therefore costs N+2 cycles with no overlap.
- The next value pop occurs in the cycle after the last write.
- With a single-entry output FIFO drained every other cycle, output throughput is one word per two cycles. The kernel imposes no additional bubbles.
- `zero_runs` updates on the clock edge that pops the zero count.

## Structure
- Package `rle_pkg`: state enum {`S_VAL`, `S_CNT`, `S_EMIT`}, token-order constants (`RLE_TOK_VAL`=0, `RLE_TOK_CNT`=1), and default `WIDTH`/`CNT_WIDTH`. The encoder kernel shares this package.
- One natural sub-module: `rle_run_counter`. It is a loadable down-counter of CNT_WIDTH bits with `load`, `dec`, and a `last` (=1) flag.
- The FSM, `val_q`, and `zero_runs` stay in the kernel.

## Test plan
- Tokens (0x00AB, 3), (0x1234, 1), with output never full → output stream 0xAB, 0xAB, 0xAB, 0x1234. First write occurs 2 cycles after the value pop, and `busy` returns to 0 after the last write.
- Token (0x0055, 0) followed by (0x0066, 2) → output 0x66, 0x66 only, and `zero_runs` = 1.
- Token (0x7777, 4) with `afull_S2` toggling 1,0,1,0… → exactly four 0x7777 writes, no write while `afull_S2`=1, and `read_S1`=0 throughout `S_EMIT`.
- Value 0x0001 available, count word delayed 5 cycles → FSM held in `S_CNT` with no writes. After the count (3) arrives, three 0x0001 writes follow.
- Token (0x00FF, 0xFFFF) → exactly 65535 writes, then `S_VAL`. An upper-bit-set count with CNT_WIDTH=8, e.g. 0xFF02, yields 2 writes.
- `rst` pulled low after 2 of 5 writes of (0x0ABC, 5) → immediately `write_S2`=0, `output_S2`=0, `zero_runs`=0. After release, the next token (0x0DEF, 1) yields a single 0x0DEF.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE encoder/decoder kernels.
package rle_pkg;

  typedef enum logic [1:0] {
    S_VAL  = 2'd0,
    S_CNT  = 2'd1,
    S_EMIT = 2'd2
  } rle_state_e;

  // Position of each word within a (value, count) token.
  localparam int unsigned RLE_TOK_VAL = 0;
  localparam int unsigned RLE_TOK_CNT = 1;

  localparam int unsigned RLE_WIDTH     = 16;
  localparam int unsigned RLE_CNT_WIDTH = 16;

endpackage

// File: rtl/kernel_rle_decode_if.sv
// S1 read / S2 write FIFO handshake shared by the streaming kernels.
interface kernel_rle_decode_if
  import rle_pkg::*;
#(
  parameter int unsigned WIDTH = RLE_WIDTH
) ();

  logic [WIDTH-1:0] input_S1;
  logic             avail_S1;
  logic             read_S1;
  logic [WIDTH-1:0] output_S2;
  logic             write_S2;
  logic             afull_S2;

  // Kernel side.
  modport master (
    input  input_S1, avail_S1, afull_S2,
    output read_S1, output_S2, write_S2
  );

  // FIFO side.
  modport slave (
    output input_S1, avail_S1, afull_S2,
    input  read_S1, output_S2, write_S2
  );

endinterface

// File: rtl/rle_run_counter.sv
// Loadable down-counter tracking how many copies of the current run remain.
module rle_run_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 dec,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 last
);

  logic [CNT_WIDTH-1:0] rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
    end else if (load) begin
      rem_q <= load_val;
    end else if (dec) begin
      rem_q <= rem_q - 1'b1;
    end
  end

  assign count = rem_q;
  assign last  = (rem_q == {{(CNT_WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/kernel_rle_decode.sv
// Run-length decoder: expands (value, count) token pairs into count copies of value.
module kernel_rle_decode
  import rle_pkg::*;
#(
  parameter int unsigned WIDTH     = RLE_WIDTH,
  parameter int unsigned CNT_WIDTH = RLE_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  kernel_rle_decode_if.master       bus,
  output logic [15:0]               zero_runs,
  output logic                      busy
);

  rle_state_e           state_q;
  logic [WIDTH-1:0]     val_q;
  logic [15:0]          zero_runs_q;
  logic [CNT_WIDTH-1:0] cnt_in;
  logic [CNT_WIDTH-1:0] rem;
  logic                 rem_last;
  logic                 cnt_zero;
  logic                 run_load;

  // Upper bits of the count word are deliberately ignored.
  assign cnt_in   = bus.input_S1[CNT_WIDTH-1:0];
  assign cnt_zero = (cnt_in == '0);

  always_comb begin
    bus.read_S1  = 1'b0;
    bus.write_S2 = 1'b0;
    unique case (state_q)
      S_VAL, S_CNT: bus.read_S1  = bus.avail_S1;
      S_EMIT:       bus.write_S2 = !bus.afull_S2;
      default:      ;
    endcase
  end

  assign run_load      = (state_q == S_CNT) && bus.avail_S1 && !cnt_zero;
  assign bus.output_S2 = val_q;
  assign zero_runs     = zero_runs_q;
  assign busy          = (state_q != S_VAL);

  rle_run_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_run_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (run_load),
    .dec      (bus.write_S2),
    .load_val (cnt_in),
    .count    (rem),
    .last     (rem_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_VAL;
      val_q       <= '0;
      zero_runs_q <= '0;
    end else begin
      unique case (state_q)
        S_VAL: begin
          if (bus.avail_S1) begin
            val_q   <= bus.input_S1;
            state_q <= S_CNT;
          end
        end
        S_CNT: begin
          if (bus.avail_S1) begin
            if (cnt_zero) begin
              if (zero_runs_q != 16'hFFFF) begin
                zero_runs_q <= zero_runs_q + 16'd1;
              end
              state_q <= S_VAL;
            end else begin
              state_q <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (!bus.afull_S2 && rem_last) begin
            state_q <= S_VAL;
          end
        end
        default: state_q <= S_VAL;
      endcase
    end
  end

  // rem is only observed through rem_last.
  logic unused_rem;
  assign unused_rem = ^rem;

endmodule

// File: tb/tb_kernel_rle_decode.sv
// Directed bench for kernel_rle_decode, including a CNT_WIDTH=8 instance.
module tb_kernel_rle_decode;
  import rle_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  kernel_rle_decode_if #(.WIDTH(16)) bus ();
  kernel_rle_decode_if #(.WIDTH(16)) bus8 ();
  logic [15:0] zero_runs, zero_runs8;
  logic        busy, busy8;

  kernel_rle_decode #(.WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .zero_runs (zero_runs),
    .busy      (busy)
  );

  kernel_rle_decode #(.WIDTH(16), .CNT_WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus8),
    .zero_runs (zero_runs8),
    .busy      (busy8)
  );

  int tests  = 0;
  int errors = 0;

  logic [15:0] in_q[$];
  logic [15:0] in8_q[$];
  logic [15:0] out_q[$];
  logic [15:0] out8_q[$];
  logic        afull_tog = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    bus.avail_S1  = (in_q.size() != 0);
    bus.input_S1  = (in_q.size() != 0) ? in_q[0] : 16'h0;
    bus8.avail_S1 = (in8_q.size() != 0);
    bus8.input_S1 = (in8_q.size() != 0) ? in8_q[0] : 16'h0;
  endtask

  // One clock: sample at the falling edge, update the input FIFO models after the rising edge.
  task automatic tick();
    logic pop, pop8;
    @(negedge clk);
    pop  = bus.read_S1;
    pop8 = bus8.read_S1;
    if (bus.write_S2) begin
      out_q.push_back(bus.output_S2);
      check("write_while_afull", {31'd0, bus.afull_S2}, 32'd0);
      check("read_with_write", {31'd0, bus.read_S1}, 32'd0);
    end
    if (dut.state_q == S_EMIT) check("read_in_emit", {31'd0, bus.read_S1}, 32'd0);
    if (bus8.write_S2) out8_q.push_back(bus8.output_S2);
    @(posedge clk);
    #1;
    if (pop && in_q.size() != 0) void'(in_q.pop_front());
    if (pop8 && in8_q.size() != 0) void'(in8_q.pop_front());
    if (afull_tog) bus.afull_S2 = ~bus.afull_S2;
    refresh();
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, {31'd0, out_q.size() >= n}, 32'd1);
  endtask

  initial begin
    int bad;
    bus.afull_S2  = 1'b0;
    bus8.afull_S2 = 1'b0;
    refresh();

    // Reset state, with a token already waiting.
    in_q = '{16'h00AB, 16'd3, 16'h1234, 16'd1};
    refresh();
    #12;
    check("rst_write", {31'd0, bus.write_S2}, 32'd0);
    check("rst_output", {16'd0, bus.output_S2}, 32'd0);
    check("rst_zero_runs", {16'd0, zero_runs}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_read_follows_avail", {31'd0, bus.read_S1}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // (AB,3),(1234,1): first write two cycles after the value pop.
    tick();
    tick();
    check("t1_first_write_t2", {31'd0, bus.write_S2}, 32'd1);
    check("t1_first_output", {16'd0, bus.output_S2}, 32'h00AB);
    repeat (6) tick();
    check("t1_count", out_q.size(), 32'd4);
    check("t1_w0", {16'd0, out_q[0]}, 32'h00AB);
    check("t1_w2", {16'd0, out_q[2]}, 32'h00AB);
    check("t1_w3", {16'd0, out_q[3]}, 32'h1234);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // Zero-length run is dropped and counted.
    out_q.delete();
    in_q = '{16'h0055, 16'd0, 16'h0066, 16'd2};
    refresh();
    run_until("t2_timeout", 2, 20);
    repeat (3) tick();
    check("t2_count", out_q.size(), 32'd2);
    check("t2_w0", {16'd0, out_q[0]}, 32'h0066);
    check("t2_w1", {16'd0, out_q[1]}, 32'h0066);
    check("t2_zero_runs", {16'd0, zero_runs}, 32'd1);

    // Backpressure toggling every cycle.
    out_q.delete();
    bus.afull_S2 = 1'b1;
    afull_tog    = 1'b1;
    in_q = '{16'h7777, 16'd4};
    refresh();
    run_until("t3_timeout", 4, 30);
    repeat (3) tick();
    afull_tog    = 1'b0;
    bus.afull_S2 = 1'b0;
    check("t3_count", out_q.size(), 32'd4);
    bad = 0;
    foreach (out_q[i]) if (out_q[i] !== 16'h7777) bad++;
    check("t3_values", bad, 32'd0);

    // Count word arrives late: hold in S_CNT.
    out_q.delete();
    in_q = '{16'h0001};
    refresh();
    tick();
    repeat (5) tick();
    check("t4_busy_wait", {31'd0, busy}, 32'd1);
    check("t4_no_write", {31'd0, bus.write_S2}, 32'd0);
    check("t4_no_output", out_q.size(), 32'd0);
    in_q.push_back(16'd3);
    refresh();
    run_until("t4_timeout", 3, 20);
    repeat (3) tick();
    check("t4_count", out_q.size(), 32'd3);
    check("t4_w2", {16'd0, out_q[2]}, 32'h0001);

    // Maximum run length.
    out_q.delete();
    in_q = '{16'h00FF, 16'hFFFF};
    refresh();
    run_until("t5_timeout", 65535, 70000);
    check("t5_busy_after", {31'd0, busy}, 32'd0);
    tick();
    check("t5_count", out_q.size(), 32'd65535);
    bad = 0;
    foreach (out_q[i]) if (out_q[i] !== 16'h00FF) bad++;
    check("t5_values", bad, 32'd0);

    // CNT_WIDTH=8 ignores upper count bits.
    in8_q = '{16'h00AA, 16'hFF02};
    refresh();
    repeat (10) tick();
    check("t5b_count", out8_q.size(), 32'd2);
    check("t5b_w1", {16'd0, out8_q[1]}, 32'h00AA);
    check("t5b_idle", {31'd0, busy8}, 32'd0);

    // Asynchronous reset mid-run.
    out_q.delete();
    in_q = '{16'h0ABC, 16'd5};
    refresh();
    run_until("t6_timeout", 2, 20);
    check("t6_pre_zero_runs", {16'd0, zero_runs}, 32'd1);
    check("t6_pre_write", {31'd0, bus.write_S2}, 32'd1);
    rst = 1'b0;
    #1;
    check("t6_rst_write", {31'd0, bus.write_S2}, 32'd0);
    check("t6_rst_output", {16'd0, bus.output_S2}, 32'd0);
    check("t6_rst_zero_runs", {16'd0, zero_runs}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    out_q.delete();
    in_q = '{16'h0DEF, 16'd1};
    refresh();
    run_until("t6_post_timeout", 1, 10);
    repeat (3) tick();
    check("t6_post_count", out_q.size(), 32'd1);
    check("t6_post_value", {16'd0, out_q[0]}, 32'h0DEF);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
